// File: rtl/dclk_burst_if.sv
// Requester/generator signal bundle for dclk_burst_arbiter.
// DCLK_ABORT_EN adds the abort request and the aborted status.
interface dclk_burst_if #(
    parameter int LEN_W = 8
);
    logic             req0;
    logic [LEN_W-1:0] len0;
    logic             gnt0;
    logic             done0;
    logic             req1;
    logic [LEN_W-1:0] len1;
    logic             gnt1;
    logic             done1;
    logic             gen_en;
    logic             period_tick;
    logic             busy;
`ifdef DCLK_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output req0, len0, req1, len1, abort,
        input  gnt0, done0, gnt1, done1, gen_en, period_tick, busy, aborted
    );
    modport slave (
        input  req0, len0, req1, len1, abort,
        output gnt0, done0, gnt1, done1, gen_en, period_tick, busy, aborted
    );
`else
    modport master (
        output req0, len0, req1, len1,
        input  gnt0, done0, gnt1, done1, gen_en, period_tick, busy
    );
    modport slave (
        input  req0, len0, req1, len1,
        output gnt0, done0, gnt1, done1, gen_en, period_tick, busy
    );
`endif
endinterface

// File: rtl/dclk_burst_arbiter.sv
// Round-robin owner of a shared two-phase clock generator: enables it for len periods, then gaps.
// Optional feature macro DCLK_ABORT_EN: period-aligned early termination with an aborted flag.
module dclk_burst_arbiter #(
    parameter int CLK_DIV    = 20,
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    dclk_burst_if.slave  bus
);
    localparam int PERIOD = 2 * CLK_DIV;
    localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             ptr_reg, ptr_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [PH_W-1:0]  phase_reg, phase_next;
    logic [LEN_W-1:0] period_reg, period_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             win;

    logic gnt0_reg, gnt1_reg, done0_reg, done1_reg;
    logic gen_en_reg, period_tick_reg, busy_reg;

`ifdef DCLK_ABORT_EN
    logic abort_pend_reg, abort_pend_next;
    logic cut_next;
    logic aborted_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            ptr_reg         <= 1'b0;
            len_reg         <= '0;
            phase_reg       <= '0;
            period_reg      <= '0;
            gap_reg         <= '0;
            gnt0_reg        <= 1'b0;
            gnt1_reg        <= 1'b0;
            done0_reg       <= 1'b0;
            done1_reg       <= 1'b0;
            gen_en_reg      <= 1'b0;
            period_tick_reg <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef DCLK_ABORT_EN
            abort_pend_reg  <= 1'b0;
            aborted_reg     <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            ptr_reg         <= ptr_next;
            len_reg         <= len_next;
            phase_reg       <= phase_next;
            period_reg      <= period_next;
            gap_reg         <= gap_next;
            // Outputs are registered from the next state so they line up with it cycle for cycle.
            gnt0_reg        <= (state_next == RUN || state_next == DONE) && !owner_next;
            gnt1_reg        <= (state_next == RUN || state_next == DONE) && owner_next;
            done0_reg       <= (state_next == DONE) && !owner_next;
            done1_reg       <= (state_next == DONE) && owner_next;
            gen_en_reg      <= (state_next == RUN);
            period_tick_reg <= (state_next == RUN) && (phase_next == PH_W'(PERIOD - 1));
            busy_reg        <= (state_next != IDLE);
`ifdef DCLK_ABORT_EN
            abort_pend_reg  <= abort_pend_next;
            aborted_reg     <= (state_next == DONE) && cut_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        len_next    = len_reg;
        phase_next  = phase_reg;
        period_next = period_reg;
        gap_next    = gap_reg;
        win         = 1'b0;
`ifdef DCLK_ABORT_EN
        abort_pend_next = 1'b0;
        cut_next        = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win         = (bus.req0 && bus.req1) ? ptr_reg : bus.req1;
                    owner_next  = win;
                    ptr_next    = ~win;
                    len_next    = win ? bus.len1 : bus.len0;
                    phase_next  = '0;
                    period_next = '0;
                    state_next  = (len_next == '0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef DCLK_ABORT_EN
                abort_pend_next = abort_pend_reg || bus.abort;
`endif
                if (phase_reg == PH_W'(PERIOD - 1)) begin
                    phase_next = '0;
                    if (period_reg == len_reg - LEN_W'(1)) begin
                        state_next = DONE;
`ifdef DCLK_ABORT_EN
                        abort_pend_next = 1'b0;
                    end else if (abort_pend_reg || bus.abort) begin
                        // Abort only ever takes effect on a period boundary.
                        state_next      = DONE;
                        cut_next        = 1'b1;
                        abort_pend_next = 1'b0;
`endif
                    end else begin
                        period_next = period_reg + LEN_W'(1);
                    end
                end else begin
                    phase_next = phase_reg + PH_W'(1);
                end
            end
            DONE: begin
                gap_next   = '0;
                state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.gnt0        = gnt0_reg;
    assign bus.gnt1        = gnt1_reg;
    assign bus.done0       = done0_reg;
    assign bus.done1       = done1_reg;
    assign bus.gen_en      = gen_en_reg;
    assign bus.period_tick = period_tick_reg;
    assign bus.busy        = busy_reg;
`ifdef DCLK_ABORT_EN
    assign bus.aborted     = aborted_reg;
`endif

endmodule

// File: tb/tb_dclk_burst_arbiter.sv
// Directed bench for dclk_burst_arbiter (CLK_DIV=4, PERIOD=8, GAP_CYCLES=2); cycle traces vs hand timelines.
module tb_dclk_burst_arbiter;
    localparam int CLK_DIV    = 4;
    localparam int LEN_W      = 8;
    localparam int GAP_CYCLES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Trace bit c holds the output value after clock edge c of a capture.
    logic [99:1] tr_gen, tr_tick, tr_g0, tr_g1, tr_d0, tr_d1, tr_busy, tr_ab;

`ifdef DCLK_ABORT_EN
    int abort_cycle  = -1;
    int abort_cycle2 = -1;
`endif

    dclk_burst_if #(.LEN_W(LEN_W)) bus ();

    dclk_burst_arbiter #(
        .CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.len0 = '0; bus.len1 = '0;
`ifdef DCLK_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Inputs changed "at c" are applied just before edge c, so they are sampled by edge c.
    task automatic capture(input int n, input int drop0, input int drop1,
                           input int rst_lo, input int rst_hi);
        tr_gen = '0; tr_tick = '0; tr_g0 = '0; tr_g1 = '0;
        tr_d0 = '0; tr_d1 = '0; tr_busy = '0; tr_ab = '0;
        for (int c = 1; c <= n; c++) begin
            if (c == drop0)  bus.req0 = 1'b0;
            if (c == drop1)  bus.req1 = 1'b0;
            if (c == rst_lo) rst_n = 1'b0;
            if (c == rst_hi) rst_n = 1'b1;
`ifdef DCLK_ABORT_EN
            bus.abort = (c == abort_cycle) || (c == abort_cycle2);
`endif
            tick();
            tr_gen[c]  = bus.gen_en;
            tr_tick[c] = bus.period_tick;
            tr_g0[c]   = bus.gnt0;
            tr_g1[c]   = bus.gnt1;
            tr_d0[c]   = bus.done0;
            tr_d1[c]   = bus.done1;
            tr_busy[c] = bus.busy;
`ifdef DCLK_ABORT_EN
            tr_ab[c]   = bus.aborted;
`endif
        end
`ifdef DCLK_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        bus.req0 = 1'b1; bus.len0 = 8'd3; bus.req1 = 1'b0; bus.len1 = '0;
`ifdef DCLK_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick(); tick(); tick();
        outs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.gen_en, bus.period_tick, bus.busy, 1'b0};
`ifdef DCLK_ABORT_EN
        outs[0] = bus.aborted;
`endif
        n_checks++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b expected 00000000", outs); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.gnt0, bus.gen_en, bus.busy} !== 3'b111) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 111", {bus.gnt0, bus.gen_en, bus.busy});
        end
        $display("reset: outputs %b, first grant gnt0=%0d", outs, bus.gnt0);
    endtask

    task automatic test_single_burst();
        do_reset();
        bus.req0 = 1'b1; bus.len0 = 8'd3;
        capture(30, 2, 0, 0, 0);
        n_checks++;
        if (tr_g0[1] !== 1'b1) begin n_fail++; $display("FAIL single_gnt_latency: got %0d expected 1", tr_g0[1]); end
        n_checks++;
        if ($countones(tr_gen) != 24 || tr_gen[1] !== 1'b1 || tr_gen[24] !== 1'b1) begin
            n_fail++; $display("FAIL single_gen_len: got %0d cycles expected 24 from cycle 1", $countones(tr_gen));
        end
        n_checks++;
        if ($countones(tr_tick) != 3 || tr_tick[8] !== 1'b1 || tr_tick[16] !== 1'b1 || tr_tick[24] !== 1'b1) begin
            n_fail++; $display("FAIL single_ticks: got %0d ticks expected 3 at 8/16/24", $countones(tr_tick));
        end
        n_checks++;
        if ($countones(tr_d0) != 1 || tr_d0[25] !== 1'b1 || tr_g0[25] !== 1'b1) begin
            n_fail++; $display("FAIL single_done: got done0 at25=%0d count=%0d expected 1/1", tr_d0[25], $countones(tr_d0));
        end
        n_checks++;
        if ({tr_g0[26], tr_gen[26], tr_busy[26], tr_busy[27], tr_busy[28]} !== 5'b00110) begin
            n_fail++; $display("FAIL single_gap: got %b expected 00110",
                               {tr_g0[26], tr_gen[26], tr_busy[26], tr_busy[27], tr_busy[28]});
        end
        n_checks++;
        if ($countones(tr_d0 & ~tr_g0) != 0 || $countones(tr_g1 | tr_d1) != 0) begin
            n_fail++; $display("FAIL single_done_without_gnt: got %0d expected 0", $countones(tr_d0 & ~tr_g0));
        end
        $display("single burst: len=3 gen_en=%0d ticks=%0d done0=%0d", $countones(tr_gen), $countones(tr_tick), $countones(tr_d0));
    endtask

    task automatic test_contention();
        do_reset();
        bus.req0 = 1'b1; bus.len0 = 8'd1; bus.req1 = 1'b1; bus.len1 = 8'd1;
        capture(26, 2, 14, 0, 0);
        n_checks++;
        if ($countones(tr_gen & tr_g0) != 8 || $countones(tr_gen & tr_g1) != 8) begin
            n_fail++; $display("FAIL contention_split: got %0d/%0d expected 8/8",
                               $countones(tr_gen & tr_g0), $countones(tr_gen & tr_g1));
        end
        n_checks++;
        if ($countones(tr_g0 & tr_g1) != 0) begin
            n_fail++; $display("FAIL contention_overlap: got %0d expected 0", $countones(tr_g0 & tr_g1));
        end
        n_checks++;
        if ({tr_g0[1], tr_d0[9], tr_busy[12], tr_g1[12], tr_g1[13], tr_d1[21]} !== 6'b110011) begin
            n_fail++; $display("FAIL contention_timing: got %b expected 110011",
                               {tr_g0[1], tr_d0[9], tr_busy[12], tr_g1[12], tr_g1[13], tr_d1[21]});
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        capture(3, 2, 2, 0, 0);
        n_checks++;
        if ({tr_g0[1], tr_g1[1]} !== 2'b10) begin
            n_fail++; $display("FAIL contention_rr_repeat: got %b expected 10", {tr_g0[1], tr_g1[1]});
        end
        $display("contention: req0 then req1 served, repeat gnt0=%0d gnt1=%0d", tr_g0[1], tr_g1[1]);
    endtask

    task automatic test_zero_length();
        do_reset();
        bus.req1 = 1'b1; bus.len1 = 8'd0;
        capture(6, 0, 2, 0, 0);
        n_checks++;
        if ({tr_g1[1], tr_d1[1], tr_g1[2], tr_busy[2], tr_busy[4]} !== 5'b11010) begin
            n_fail++; $display("FAIL zero_len_timing: got %b expected 11010",
                               {tr_g1[1], tr_d1[1], tr_g1[2], tr_busy[2], tr_busy[4]});
        end
        n_checks++;
        if ($countones(tr_gen) != 0 || $countones(tr_tick) != 0 || $countones(tr_d1) != 1) begin
            n_fail++; $display("FAIL zero_len_no_gen: got gen=%0d ticks=%0d done1=%0d expected 0/0/1",
                               $countones(tr_gen), $countones(tr_tick), $countones(tr_d1));
        end
        $display("zero length: gnt1=%0d done1=%0d gen_en=%0d", tr_g1[1], tr_d1[1], $countones(tr_gen));
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req0 = 1'b1; bus.len0 = 8'd5;
        capture(56, 14, 0, 11, 13);
        n_checks++;
        if ($countones(tr_gen[12:1]) != 10 || {tr_gen[11], tr_g0[11], tr_tick[11], tr_busy[11]} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_kill: got gen=%0d flags=%b expected 10/0000",
                               $countones(tr_gen[12:1]), {tr_gen[11], tr_g0[11], tr_tick[11], tr_busy[11]});
        end
        n_checks++;
        if ($countones(tr_d0[12:1]) != 0) begin
            n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", $countones(tr_d0[12:1]));
        end
        n_checks++;
        if ($countones(tr_gen[52:13]) != 40 || tr_g0[13] !== 1'b1 || tr_gen[53] !== 1'b0 || tr_d0[53] !== 1'b1) begin
            n_fail++; $display("FAIL midreset_fresh_burst: got gen=%0d done53=%0d expected 40/1",
                               $countones(tr_gen[52:13]), tr_d0[53]);
        end
        $display("reset mid-burst: pre=%0d fresh=%0d done0=%0d", $countones(tr_gen[12:1]),
                 $countones(tr_gen[52:13]), $countones(tr_d0));
    endtask

`ifdef DCLK_ABORT_EN
    task automatic test_abort();
        do_reset();
        bus.req0 = 1'b1; bus.len0 = 8'd4;
        abort_cycle  = 12;   // high during gen_en cycle 11
        abort_cycle2 = 19;   // high during a GAP cycle
        capture(24, 2, 0, 0, 0);
        abort_cycle = -1; abort_cycle2 = -1;
        n_checks++;
        if ($countones(tr_gen) != 16 || tr_gen[16] !== 1'b1 || tr_gen[17] !== 1'b0) begin
            n_fail++; $display("FAIL abort_gen_len: got %0d expected 16", $countones(tr_gen));
        end
        n_checks++;
        if ({tr_d0[17], tr_ab[17]} !== 2'b11 || $countones(tr_ab) != 1 || $countones(tr_d0) != 1) begin
            n_fail++; $display("FAIL abort_flag: got done=%0d aborted=%0d expected 1/1", tr_d0[17], tr_ab[17]);
        end
        n_checks++;
        if (tr_busy[20] !== 1'b0 || $countones(tr_gen[24:18]) != 0) begin
            n_fail++; $display("FAIL abort_in_gap: got busy20=%0d expected 0", tr_busy[20]);
        end
        $display("abort: gen_en=%0d aborted=%0d", $countones(tr_gen), tr_ab[17]);
    endtask
`endif

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.len0 = '0; bus.len1 = '0;
`ifdef DCLK_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_single_burst();
        test_contention();
        test_zero_length();
        test_reset_mid_burst();
`ifdef DCLK_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
